// File: rtl/seq_divider_64by32.sv
// Unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per
// clock, with valid/ready handshakes on both the operand and the result side.
module seq_divider_64by32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] part_next;

  // The partial remainder stays below the divisor, so only its low WIDTH bits need storing;
  // the trial subtraction itself is carried out at WIDTH+1 bits.
  always_comb begin
    trial     = {part_q, lo_q[WIDTH-1]};
    diff      = trial - {1'b0, dvsr_q};
    qbit      = ~diff[WIDTH];
    part_next = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      part_q  <= '0;
      lo_q    <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            dvsr_q <= divisor;
            if (divisor == '0) begin
              dbz_q   <= 1'b1;
              ovf_q   <= 1'b0;
              quo_q   <= '1;
              rem_q   <= dividend[WIDTH-1:0];
              state_q <= StDone;
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              // Quotient would need more than WIDTH bits.
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b1;
              quo_q   <= '1;
              rem_q   <= '0;
              state_q <= StDone;
            end else begin
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b0;
              part_q  <= dividend[2*WIDTH-1:WIDTH];
              lo_q    <= dividend[WIDTH-1:0];
              quo_q   <= '0;
              cnt_q   <= CntW'(WIDTH - 1);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          part_q <= part_next;
          lo_q   <= lo_q << 1;
          quo_q  <= {quo_q[WIDTH-2:0], qbit};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            rem_q   <= part_next;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider_64by32.sv
// Directed and random checks of seq_divider_64by32 against a plain-arithmetic reference model.
module tb_seq_divider_64by32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_cmp;
  int n_err;

  seq_divider_64by32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic model(input logic [63:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output int lat);
    longint unsigned qq;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 32'd0) begin
      dz = 1'b1; q = '1; r = a[31:0]; lat = 1;
    end else begin
      qq = a / {32'd0, b};
      if (qq > 64'hFFFF_FFFF) begin
        ov = 1'b1; q = '1; r = '0; lat = 1;
      end else begin
        q = qq[31:0];
        r = 32'(a % {32'd0, b});
        lat = 33;
      end
    end
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: observed no out_valid expected out_valid within 200 cycles", tag);
    end
  endtask

  // One full operation; ready_delay cycles of backpressure; hold keeps in_valid asserted.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [31:0] b,
                       input int ready_delay, input bit hold);
    logic [31:0] eq, er;
    logic        edz, eov;
    int          elat, lat, w;
    model(a, b, eq, er, edz, eov, elat);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = (ready_delay == 0);
    w = 0;
    while (!in_ready && w < 100) begin
      step();
      w++;
    end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    step();
    if (!hold) in_valid = 1'b0;
    wait_valid(tag, lat);
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, edz);
    check({tag, "_ovf"}, overflow, eov);
    for (int i = 0; i < ready_delay; i++) begin
      step();
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
      check({tag, "_hold_q"}, quotient, eq);
      check({tag, "_hold_r"}, remainder, er);
    end
    out_ready = 1'b1;
    step();
    check({tag, "_post_valid"}, out_valid, 1'b0);
    check({tag, "_post_ready"}, in_ready, 1'b1);
    check({tag, "_post_q"}, quotient, eq);
    out_ready = 1'b0;
    if (hold) begin
      // The held in_valid is only now accepted, one cycle after the output handshake.
      step();
      in_valid = 1'b0;
      check({tag, "_second_accept"}, in_ready, 1'b0);
      out_ready = 1'b1;
      wait_valid({tag, "_second"}, lat);
      check({tag, "_second_q"}, quotient, eq);
      check({tag, "_second_r"}, remainder, er);
      step();
      out_ready = 1'b0;
    end
  endtask

  logic [63:0] ra;
  logic [31:0] rb;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    check("reset_dbz", div_by_zero, 1'b0);
    check("reset_ovf", overflow, 1'b0);

    do_op("basic", 64'd100, 32'd7, 0, 1'b0);
    do_op("mulinv", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 0, 1'b0);
    do_op("divzero", 64'h0000_0000_1234_5678, 32'd0, 0, 1'b0);
    do_op("ovf", 64'h0000_0001_0000_0000, 32'd1, 0, 1'b0);
    do_op("ovf_edge", 64'h0000_0005_0000_0000, 32'd5, 0, 1'b0);
    do_op("max_ok", 64'h0000_0004_FFFF_FFFF, 32'd5, 0, 1'b0);
    do_op("backpressure", 64'd1000, 32'd3, 5, 1'b1);

    // Reset ten cycles into a calculation.
    in_valid  = 1'b1;
    dividend  = 64'h0000_0123_4567_89AB;
    divisor   = 32'h0001_0000;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_flags", {div_by_zero, overflow}, 2'b00);
    out_ready = 1'b0;
    do_op("after_rst", 64'd65535, 32'd256, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rb = $urandom;
      if (i % 7 == 3) rb = 32'd0;
      if (i % 5 == 4) rb = rb >> $urandom_range(31, 16);
      ra = {$urandom, $urandom};
      if ((i % 2 == 1) && rb != 32'd0) ra[63:32] = ra[63:32] % rb;
      do_op("random", ra, rb, int'($urandom_range(3, 0)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
